// File: rtl/add_arbiter.sv
// add_arbiter: two-requester round-robin front end for one shared signed adder.
// A single-entry output register holds the (n+1)-bit sum tagged with the
// winning requester's ID. The register may drain and accept in the same cycle.
module add_arbiter #(
  parameter int n = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req0_valid,
  input  logic signed [n-1:0] req0_x,
  input  logic signed [n-1:0] req0_y,
  output logic                req0_ready,
  input  logic                req1_valid,
  input  logic signed [n-1:0] req1_x,
  input  logic signed [n-1:0] req1_y,
  output logic                req1_ready,
  output logic                res_valid,
  output logic                res_id,
  output logic signed [n:0]   res_s,
  input  logic                res_ready
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t              state_q, state_d;
  logic                ptr_q, ptr_d;
  logic                res_id_q, res_id_d;
  logic signed [n:0]   res_s_q, res_s_d;

  logic                avail;
  logic                win;
  logic                xfer;
  logic signed [n-1:0] op_x, op_y;
  logic signed [n:0]   sum;

  // Full-precision signed add. Sign-extending to n+1 bits means the sum cannot overflow.
  function automatic logic signed [n:0] add_sext(input logic signed [n-1:0] a,
                                                 input logic signed [n-1:0] b);
    logic signed [n:0] ae, be;
    ae = {a[n-1], a};
    be = {b[n-1], b};
    return ae + be;
  endfunction

  // Grant, handshake and operand mux. The readies are forced low while reset is
  // asserted, so a handshake cannot complete during reset.
  always_comb begin
    avail      = (state_q == EMPTY) | res_ready;
    win        = req1_valid & (~req0_valid | ptr_q);
    req0_ready = ~rst & avail & req0_valid & ~win;
    req1_ready = ~rst & avail & win;
    xfer       = req0_ready | req1_ready;
    op_x       = win ? req1_x : req0_x;
    op_y       = win ? req1_y : req0_y;
    sum        = add_sext(op_x, op_y);
  end

  // Next state: load on transfer and hand priority to the loser. Otherwise clear
  // res_valid when the result drains. The held data and ptr do not change otherwise.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    res_id_d = res_id_q;
    res_s_d  = res_s_q;
    if (xfer) begin
      state_d  = FULL;
      res_s_d  = sum;
      res_id_d = win;
      ptr_d    = ~win;
    end else if ((state_q == FULL) && res_ready) begin
      state_d = EMPTY;
    end
  end

  // State and output register with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= EMPTY;
      ptr_q    <= 1'b0;
      res_id_q <= 1'b0;
      res_s_q  <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      res_id_q <= res_id_d;
      res_s_q  <= res_s_d;
    end
  end

  assign res_valid = (state_q == FULL);
  assign res_id    = res_id_q;
  assign res_s     = res_s_q;

endmodule
